// File: rtl/alu_exec_ctrl_if.sv
// Bus bundle for alu_exec_ctrl: instruction input, external ALU hookup and result output.
interface alu_exec_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;

    logic [1:0]  alu_ctrl;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        alu_overflow;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
    logic        out_err;

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC,
        input  alu_result, alu_overflow, out_ready,
        output in_ready, alu_ctrl, alu_a, alu_b,
        output out_valid, valE, cnd, cc, out_err
    );

    modport master (
        output in_valid, icode, ifun, valA, valB, valC,
        output alu_result, alu_overflow, out_ready,
        input  in_ready, alu_ctrl, alu_a, alu_b,
        input  out_valid, valE, cnd, cc, out_err
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Y86-64 execute-stage controller sequencing one instruction at a time through an external ALU.
// Define EXEC_CC_EN to build the condition-code register and full branch/cmov condition logic.
module alu_exec_ctrl (
    input logic            clk,
    input logic            reset_n,
    alu_exec_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  icode_q;
    logic [3:0]  ifun_q;
    logic [63:0] val_a_q;
    logic [63:0] val_b_q;
    logic [63:0] val_c_q;
    logic [63:0] val_e_q;
    logic        cnd_q;
    logic        err_q;
    logic [63:0] alu_a_sel;
    logic [63:0] alu_b_sel;
    logic [1:0]  fun_sel;
    logic        cond_met;
    logic        is_err;
    logic        is_cond_op;
    logic [2:0]  cc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = EXEC;
            EXEC:    next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            val_a_q <= 64'd0;
            val_b_q <= 64'd0;
            val_c_q <= 64'd0;
        end else if (state == IDLE && bus.in_valid) begin
            icode_q <= bus.icode;
            ifun_q  <= bus.ifun;
            val_a_q <= bus.valA;
            val_b_q <= bus.valB;
            val_c_q <= bus.valC;
        end
    end

    // aluA/aluB operand selection by instruction class; invalid codes feed zeros.
    always_comb begin
        alu_a_sel = 64'd0;
        alu_b_sel = 64'd0;
        fun_sel   = 2'b00;
        case (icode_q)
            4'h6: begin alu_a_sel = val_a_q; alu_b_sel = val_b_q; fun_sel = ifun_q[1:0]; end
            4'h2: alu_a_sel = val_a_q;
            4'h3: alu_a_sel = val_c_q;
            4'h4, 4'h5: begin alu_a_sel = val_c_q; alu_b_sel = val_b_q; end
            4'h8, 4'hA: begin alu_a_sel = -64'sd8; alu_b_sel = val_b_q; end
            4'h9, 4'hB: begin alu_a_sel = 64'd8; alu_b_sel = val_b_q; end
            default: ;
        endcase
    end

    assign is_err     = (icode_q > 4'hB);
    assign is_cond_op = (icode_q == 4'h2) || (icode_q == 4'h7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_e_q <= 64'd0;
            cnd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == EXEC) begin
            val_e_q <= is_err ? 64'd0 : bus.alu_result;
            cnd_q   <= is_cond_op && cond_met;
            err_q   <= is_err;
        end
    end

`ifdef EXEC_CC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cc_q <= 3'b100;
        else if (state == EXEC && icode_q == 4'h6)
            cc_q <= {bus.alu_result == 64'd0, bus.alu_result[63], bus.alu_overflow};
    end

    // cc_q still holds the pre-instruction flags while in EXEC.
    always_comb begin
        cond_met = 1'b0;
        case (ifun_q)
            4'h0: cond_met = 1'b1;
            4'h1: cond_met = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2: cond_met = cc_q[1] ^ cc_q[0];
            4'h3: cond_met = cc_q[2];
            4'h4: cond_met = !cc_q[2];
            4'h5: cond_met = !(cc_q[1] ^ cc_q[0]);
            4'h6: cond_met = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
            default: cond_met = 1'b0;
        endcase
    end
`else
    logic unused_overflow;
    assign unused_overflow = bus.alu_overflow;
    assign cc_q            = 3'b000;
    assign cond_met        = (ifun_q == 4'h0);
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.alu_ctrl  = (state == EXEC) ? fun_sel   : 2'b00;
    assign bus.alu_a     = (state == EXEC) ? alu_b_sel : 64'd0;
    assign bus.alu_b     = (state == EXEC) ? alu_a_sel : 64'd0;
    assign bus.valE      = val_e_q;
    assign bus.cnd       = cnd_q;
    assign bus.out_err   = err_q;
    assign bus.cc        = cc_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural 64-bit ALU; expectations follow EXEC_CC_EN.
module tb_alu_exec_ctrl;
`ifdef EXEC_CC_EN
    localparam bit CcOn = 1'b1;
`else
    localparam bit CcOn = 1'b0;
`endif
    localparam logic [2:0] CcReset = CcOn ? 3'b100 : 3'b000;

    typedef struct {
        logic [63:0] valE;
        logic        cnd;
        logic [2:0]  cc;
        logic        err;
        int          startCycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;
    int   cycleCount = 0;
    logic prevValid = 1'b0;
    exp_t expQ[$];

    alu_exec_ctrl_if bus();

    alu_exec_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCount++;

    // External ALU: result = alu_a OP alu_b, overflow for add/sub only.
    always_comb begin
        bus.alu_result   = 64'd0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_ctrl)
            2'b00: begin
                bus.alu_result   = bus.alu_a + bus.alu_b;
                bus.alu_overflow = (bus.alu_a[63] == bus.alu_b[63]) && (bus.alu_result[63] != bus.alu_a[63]);
            end
            2'b01: begin
                bus.alu_result   = bus.alu_a - bus.alu_b;
                bus.alu_overflow = (bus.alu_a[63] != bus.alu_b[63]) && (bus.alu_result[63] != bus.alu_a[63]);
            end
            2'b10: bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = bus.alu_a ^ bus.alu_b;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expected);
        total++;
        if (got !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, got, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] c, input logic [63:0] expE,
                                 input logic expCnd, input logic [2:0] expCc, input logic expErr);
        int   waitCount = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.in_ready && waitCount < 50) begin
            @(negedge clk);
            waitCount++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        e.valE = expE;
        e.cnd = expCnd;
        e.cc = CcOn ? expCc : 3'b000;
        e.err = expErr;
        e.startCycle = cycleCount;
        expQ.push_back(e);
        bus.in_valid = 1'b1;
        bus.icode = ic;
        bus.ifun = fn;
        bus.valA = a;
        bus.valB = b;
        bus.valC = c;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drainQueue();
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: latency on each rising out_valid, full compare on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prevValid = 1'b0;
        end else begin
            if (bus.out_valid && !prevValid) begin
                if (expQ.size() == 0) checkOutput("unexpected_out_valid", 64'd1, 64'd0);
                else checkOutput("latency", 64'(cycleCount - expQ[0].startCycle), 64'd2);
            end
            if (bus.out_valid && bus.out_ready && expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("valE", bus.valE, e.valE);
                checkOutput("cnd", 64'(bus.cnd), 64'(e.cnd));
                checkOutput("cc", 64'(bus.cc), 64'(e.cc));
                checkOutput("out_err", 64'(bus.out_err), 64'(e.err));
            end
            prevValid = bus.out_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.icode = 4'h0;
        bus.ifun = 4'h0;
        bus.valA = 64'd0;
        bus.valB = 64'd0;
        bus.valC = 64'd0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_valE", bus.valE, 64'd0);
        checkOutput("rst_cnd", 64'(bus.cnd), 64'd0);
        checkOutput("rst_err", 64'(bus.out_err), 64'd0);
        checkOutput("rst_cc", 64'(bus.cc), 64'(CcReset));
        checkOutput("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        checkOutput("rst_alu_a", bus.alu_a, 64'd0);
        checkOutput("rst_alu_b", bus.alu_b, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(4'h6, 4'h0, 64'd3, 64'd5, 64'd0, 64'd8, 1'b0, 3'b000, 1'b0);
        applyStimulus(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 3'b100, 1'b0);
        applyStimulus(4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 64'h1234, CcOn, 3'b100, 1'b0);
        applyStimulus(4'h6, 4'h0, 64'h4000000000000000, 64'h4000000000000000, 64'd0,
                      64'h8000000000000000, 1'b0, 3'b011, 1'b0);
        applyStimulus(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 3'b011, 1'b0);
        applyStimulus(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 3'b011, 1'b0);
        applyStimulus(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'b010, 1'b0);
        applyStimulus(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, CcOn, 3'b010, 1'b0);
        applyStimulus(4'h6, 4'h3, 64'hAA, 64'hAA, 64'd0, 64'd0, 1'b0, 3'b100, 1'b0);
        applyStimulus(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 3'b100, 1'b0);
        applyStimulus(4'h2, 4'h5, 64'd7, 64'd0, 64'd0, 64'd7, CcOn, 3'b100, 1'b0);
        applyStimulus(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 64'hF000, 1'b0, 3'b000, 1'b0);
        applyStimulus(4'h3, 4'h0, 64'h99, 64'd0, 64'h55, 64'h55, 1'b0, 3'b000, 1'b0);
        applyStimulus(4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 64'h30, 1'b0, 3'b000, 1'b0);
        applyStimulus(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8, 1'b0, 3'b000, 1'b0);
        applyStimulus(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 64'h100, 1'b0, 3'b000, 1'b0);

        // Back-pressure with an invalid opcode while another instruction is offered.
        drainQueue();
        bus.out_ready = 1'b0;
        applyStimulus(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0, 3'b000, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_reach_done", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b1;
        bus.icode = 4'h6;
        bus.valA = 64'd9;
        bus.valB = 64'd9;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("hold_valE", bus.valE, 64'd0);
            checkOutput("hold_err", 64'(bus.out_err), 64'd1);
            checkOutput("hold_alu_a", bus.alu_a, 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drainQueue();

        // Reset while an instruction is in EXEC.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.icode = 4'h6;
        bus.ifun = 4'h0;
        bus.valA = 64'd1;
        bus.valB = 64'd2;
        bus.valC = 64'd0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        checkOutput("exec_alu_a", bus.alu_a, 64'd2);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("midrst_cc", 64'(bus.cc), 64'(CcReset));
        checkOutput("midrst_alu_a", bus.alu_a, 64'd0);
        checkOutput("midrst_valE", bus.valE, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 3'b100, 1'b0);
        drainQueue();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid in 1, instruction offered; in_ready out 1, block can accept; icode in 4; ifun in 4; valA in 64; valB in 64; valC in 64.
REQ-003 SHALL have ports: alu_ctrl out 2, drives ALU control_signal; alu_a out 64; alu_b out 64; alu_result in 64; alu_overflow in 1. These connect to a combinational 64-bit ALU instantiated outside this block.
REQ-004 SHALL have ports: out_valid out 1; out_ready in 1; valE out 64; cnd out 1; cc out 3 {ZF,SF,OF}; out_err out 1.

Function
REQ-005 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-006 SHALL assert in_ready only in IDLE.
REQ-007 SHALL, on the clk edge where in_valid&&in_ready, latch icode/ifun/valA/valB/valC and move to EXEC.
REQ-008 SHALL, in EXEC, drive the ALU from the latched fields only and hold alu_ctrl/alu_a/alu_b at 0 in IDLE and DONE.
REQ-009 SHALL apply this aluA/aluB/fun selection:
- icode 6 (OPq): aluA=valA, aluB=valB, fun=ifun[1:0].
- icode 2 (rrmovq/cmovXX): aluA=valA, aluB=0, add.
- icode 3 (irmovq): aluA=valC, aluB=0, add.
- icode 4/5 (rmmovq/mrmovq): aluA=valC, aluB=valB, add.
- icode 8/A (call/pushq): aluA=-8, aluB=valB, add.
- icode 9/B (ret/popq): aluA=+8, aluB=valB, add.
- icode 0/1/7: aluA=0, aluB=0, add.
REQ-010 SHALL drive alu_a=aluB and alu_b=aluA; alu_ctrl encoding: 00 add, 01 sub (alu_a-alu_b), 10 and, 11 xor. Result = aluB OP aluA, with 64-bit two's-complement wrap.
REQ-011 SHALL, at the end of EXEC, register alu_result into valE and move to DONE.
REQ-012 SHALL, at the end of EXEC, update CC only when icode==6: ZF=(alu_result==0), SF=alu_result[63], OF=alu_overflow. CC SHALL NOT change for any other icode.
REQ-013 SHALL compute cnd, registered at the end of EXEC, for icode 2 or 7 from the CC value held before this instruction, using ifun:
- 0: 1; 1: (SF^OF)|ZF; 2: SF^OF; 3: ZF; 4: !ZF; 5: !(SF^OF); 6: !(SF^OF)&&!ZF; 7-F: 0.
- cnd SHALL be 0 for all other icodes.
REQ-014 SHALL, for icode > 0xB, set out_err=1, set valE=0, leave CC unchanged and set cnd=0. out_err SHALL be 0 otherwise.
REQ-015 SHALL assert out_valid only in DONE and hold valE/cnd/out_err stable until out_valid&&out_ready. It then returns to IDLE, so in_ready is high on the following cycle; there is no same-cycle accept.
REQ-016 SHALL give latency from accept edge to out_valid of 2 cycles; minimum initiation interval is 3 cycles.
REQ-017 SHALL drive cc continuously from the CC register.

Reset
REQ-018 SHALL, while reset_n==0 (asynchronously, including mid-EXEC/DONE), hold: state=IDLE, in_ready=1, out_valid=0, valE=0, cnd=0, out_err=0, CC={ZF=1,SF=0,OF=0}, alu_ctrl=0, alu_a=0, alu_b=0.
REQ-019 SHALL discard any in-flight instruction on reset; the first accept after reset_n rises SHALL behave as from power-up.

Configuration
REQ-020 SHALL compile the CC register and condition logic only when macro EXEC_CC_EN is defined.
REQ-021 SHALL, when EXEC_CC_EN is undefined, tie cc to 3'b000 and make cnd=1 only for icode 2/7 with ifun 0 (else 0). REQ-012 is then void; all other behaviour is unchanged.

Verification
REQ-022 Reset, then OPq addq (icode 6, ifun 0), valA=3, valB=5 -> out_valid 2 cycles after accept, valE=8, cc=000.
REQ-023 OPq subq, valA=5, valB=5 -> valE=0, cc=100; then cmovle (icode 2, ifun 1), valA=0x1234 -> valE=0x1234, cnd=1.
REQ-024 OPq addq, valA=valB=0x4000000000000000 -> valE=0x8000000000000000, cc=011; then jl (icode 7, ifun 2) -> cnd=0.
REQ-025 pushq (icode A), valB=0x100 -> valE=0xF8; popq (icode B), valB=0xF8 -> valE=0x100; cc unchanged.
REQ-026 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0; icode=0xC -> out_err=1, valE=0.
REQ-027 Assert reset_n=0 during EXEC -> out_valid=0, cc=100 immediately; without EXEC_CC_EN, subq result 0 -> cc=000.
